lvds_tx: RTL
============

Name: lvds_tx

Overview:
- Transmit-side counterpart of lvds_rx for the modem LVDS I/Q interface.
- Pulls 32-bit I/Q sample words from the TX complex_fifo read port.
- Frames each word with the modem I/Q sync and control bits.
- Serialises each word MSB-first as 2 bits per clock into a DDR output SB_IO that drives o_iq_tx_p/n; the forwarded clock o_iq_tx_clk is generated outside this block.

Parameters:
UNDERRUN_W, 8, width of the saturating underrun counter

Ports:
i_ddr_clk  input  1  LVDS TX clock, the only clock; all logic on posedge
i_reset  input  1  synchronous, active-high reset
i_tx_en  input  1  transmit enable from io_ctrl/smi_ctrl register
i_fifo_empty  input  1  TX FIFO empty flag
o_fifo_pull  output  1  one-cycle read strobe to FIFO rd_en
i_fifo_pulled_data  input  32  FIFO read data, valid the cycle after o_fifo_pull; I = [28:16], Q = [12:0], other bits ignored
o_ddr_data  output  2  {rising-edge bit, falling-edge bit} to SB_IO D_OUT_0/D_OUT_1
o_busy  output  1  high while a frame is being shifted
o_underrun_count  output  UNDERRUN_W  saturating count of stream underruns

Behaviour:
- Clock and reset: single clock i_ddr_clk. Reset is synchronous and active-high on i_reset.
- Reset values: state IDLE, pair counter 0, o_fifo_pull 0, o_ddr_data 2'b00, o_busy 0, o_underrun_count 0.
- Reset asserted mid-frame aborts the frame at the next edge. No partial frame resumes after reset.
- Frame format (32 bits, MSB first): {2'b10, I[12:0], 1'b0, 2'b01, Q[12:0], 1'b0}.
- Serialisation: 16 pairs per frame. Pair k = frame[31-2k : 30-2k]. o_ddr_data is registered.
- States:
  - IDLE: o_ddr_data = 00, o_busy = 0. If i_tx_en && !i_fifo_empty: pulse o_fifo_pull and go to FETCH.
  - FETCH: capture i_fifo_pulled_data, build the frame into the shift register, and go to TX with counter = 0. First pair appears on o_ddr_data in the cycle after FETCH.
  - TX: output pair[counter] and increment the counter.
    - At counter 13: if i_tx_en && !i_fifo_empty, pulse o_fifo_pull.
    - At counter 14: capture that data into the next-frame register.
    - At counter 15: if a next frame was captured, load it and wrap the counter to 0, with no idle gap between frames. Otherwise go to IDLE.
- Pull latency: 2 cycles from o_fifo_pull in IDLE to the first pair on o_ddr_data. Throughput is 1 word per 16 clocks when streaming.
- Underrun: at counter 13 with i_tx_en = 1 and i_fifo_empty = 1, increment o_underrun_count. The counter saturates at all-ones and never wraps. No increment when i_tx_en = 0.
- i_tx_en falling mid-frame: the current frame completes, all 16 pairs. No new pull is made, and the block returns to IDLE.
- o_fifo_pull is never asserted while i_fifo_empty = 1, and never more than once per frame.
- o_busy = 1 in FETCH and TX.

Decomposition:
- Shared package lvds_pkg:
  - I_SYNC = 2'b10, Q_SYNC = 2'b01
  - FRAME_PAIRS = 16, PREFETCH_PAIR = 13
  - state encoding IDLE/FETCH/TX
  - frame-build function {sync, I, ctrl, sync, Q, ctrl}, reusable by lvds_rx sync checking
- No sub-module. The block is a single FSM plus shift register.

Test Plan:
- Single word I = 13'h0AAA, Q = 13'h1555, tx_en = 1, FIFO holds 1 word -> frame 32'h9554_6AAA. Pairs in order: 10,01,01,01,01,01,01,00,01,10,10,10,10,10,10,10. Then 00 idle. o_underrun_count = 1.
- Three back-to-back words, FIFO pre-filled -> exactly 3 pull pulses, at IDLE and at counter 13 of frames 1 and 2. 48 contiguous pairs with no 00 gap. o_underrun_count = 1 after the last frame.
- tx_en = 0 with non-empty FIFO -> no o_fifo_pull, o_ddr_data = 00, counter stays 0.
- tx_en dropped at pair 5 of a frame -> remaining pairs 6..15 still output. No further pull, IDLE after pair 15, underrun count unchanged.
- i_reset asserted at pair 8 -> the next edge gives o_ddr_data = 00, o_busy = 0, o_underrun_count = 0. A new pull occurs only after reset deasserts and i_tx_en && !empty.
- Force 300 underruns with UNDERRUN_W = 8 -> o_underrun_count saturates at 8'hFF and does not wrap.

Source files
------------

// File: rtl/lvds_pkg.sv
// Shared definitions for the modem LVDS I/Q link: sync/control framing, pair
// counter landmarks and transmit state encoding, reused by the lvds_rx sync check.
package lvds_pkg;

  localparam logic [1:0] I_SYNC = 2'b10;
  localparam logic [1:0] Q_SYNC = 2'b01;

  localparam int FRAME_PAIRS   = 16;
  localparam int PREFETCH_PAIR = 13;
  localparam int PAIR_CNT_W    = $clog2(FRAME_PAIRS);

  typedef logic [PAIR_CNT_W-1:0] pair_cnt_t;

  // FIFO read data lands one pair after the prefetch strobe; the last pair decides wrap or idle.
  localparam pair_cnt_t PREFETCH_CNT = pair_cnt_t'(PREFETCH_PAIR);
  localparam pair_cnt_t CAPTURE_CNT  = pair_cnt_t'(PREFETCH_PAIR + 1);
  localparam pair_cnt_t LAST_CNT     = pair_cnt_t'(FRAME_PAIRS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    TX    = 2'd2
  } state_e;

  function automatic logic [31:0] build_frame(input logic [12:0] i_val, input logic [12:0] q_val);
    return {I_SYNC, i_val, 1'b0, Q_SYNC, q_val, 1'b0};
  endfunction

endpackage

// File: rtl/lvds_tx_if.sv
// TX complex_fifo read port: master is the puller (lvds_tx), slave is the FIFO.
interface lvds_tx_if;

  logic        fifo_empty;
  logic        fifo_pull;
  logic [31:0] fifo_pulled_data;

  modport master (
    output fifo_pull,
    input  fifo_empty,
    input  fifo_pulled_data
  );

  modport slave (
    input  fifo_pull,
    output fifo_empty,
    output fifo_pulled_data
  );

endinterface

// File: rtl/lvds_tx.sv
// LVDS I/Q serialiser: 2 cycles from first pull to first DDR pair, then 16 pairs per word.
// Pulls only when enabled and the FIFO is non-empty; an empty FIFO at prefetch ends the stream.
module lvds_tx
  import lvds_pkg::*;
#(
  parameter int UNDERRUN_W = 8
) (
  input  logic                  i_ddr_clk,
  input  logic                  i_reset,
  input  logic                  i_tx_en,
  lvds_tx_if.master             fifo,
  output logic [1:0]            o_ddr_data,
  output logic                  o_busy,
  output logic [UNDERRUN_W-1:0] o_underrun_count
);

  state_e                state_q, state_d;
  pair_cnt_t             cnt_q, cnt_d;
  logic [31:0]           shift_q, shift_d;
  logic [31:0]           next_frame_q, next_frame_d;
  logic                  pend_q, pend_d;
  logic                  next_vld_q, next_vld_d;
  logic [1:0]            ddr_q, ddr_d;
  logic [UNDERRUN_W-1:0] urun_q, urun_d;

  logic        can_pull;
  logic        pull;
  logic [31:0] pulled_frame;
  logic        unused_data_bits;

  assign can_pull     = i_tx_en && !fifo.fifo_empty;
  assign pulled_frame = build_frame(fifo.fifo_pulled_data[28:16], fifo.fifo_pulled_data[12:0]);
  assign unused_data_bits = ^{fifo.fifo_pulled_data[31:29], fifo.fifo_pulled_data[15:13]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    next_frame_d = next_frame_q;
    pend_d       = pend_q;
    next_vld_d   = next_vld_q;
    ddr_d        = ddr_q;
    urun_d       = urun_q;
    pull         = 1'b0;

    case (state_q)
      IDLE: begin
        ddr_d = 2'b00;
        cnt_d = '0;
        if (can_pull) begin
          pull    = 1'b1;
          state_d = FETCH;
        end
      end

      FETCH: begin
        ddr_d   = pulled_frame[31:30];
        shift_d = {pulled_frame[29:0], 2'b00};
        cnt_d   = '0;
        state_d = TX;
      end

      TX: begin
        // cnt_q is the pair currently on the pins; shift_q already holds the following pair.
        ddr_d   = shift_q[31:30];
        shift_d = {shift_q[29:0], 2'b00};
        cnt_d   = cnt_q + 1'b1;

        if (cnt_q == PREFETCH_CNT) begin
          if (can_pull) begin
            pull   = 1'b1;
            pend_d = 1'b1;
          end else if (i_tx_en && !(&urun_q)) begin
            urun_d = urun_q + 1'b1;
          end
        end

        if (cnt_q == CAPTURE_CNT && pend_q) begin
          next_frame_d = pulled_frame;
          next_vld_d   = 1'b1;
          pend_d       = 1'b0;
        end

        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (next_vld_q) begin
            ddr_d      = next_frame_q[31:30];
            shift_d    = {next_frame_q[29:0], 2'b00};
            next_vld_d = 1'b0;
          end else begin
            ddr_d   = 2'b00;
            state_d = IDLE;
          end
        end
      end

      default: begin
        ddr_d   = 2'b00;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_ddr_clk) begin
    if (i_reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      next_frame_q <= '0;
      pend_q       <= 1'b0;
      next_vld_q   <= 1'b0;
      ddr_q        <= 2'b00;
      urun_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      next_frame_q <= next_frame_d;
      pend_q       <= pend_d;
      next_vld_q   <= next_vld_d;
      ddr_q        <= ddr_d;
      urun_q       <= urun_d;
    end
  end

  assign fifo.fifo_pull   = pull && !i_reset;
  assign o_ddr_data       = ddr_q;
  assign o_busy           = (state_q != IDLE);
  assign o_underrun_count = urun_q;

endmodule
